// File: rtl/axis_demux_13.sv
// axis_demux_13 -- 1-to-3 AXI4-Stream packet router.
// The head beat's TUSER destination field steers the whole packet to one of
// three master streams through a single shared output register. Packets for
// an illegal (3) or disabled destination are swallowed and counted.
module axis_demux_13 #(
   parameter int TDATA_L  = 512,
   parameter int TUSER_L  = 81,
   parameter int TKEEP_L  = 16,
   parameter int DEST_LSB = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2:0]         port_enable_i,
   input  logic [TDATA_L-1:0] axi_s_tdata_i,
   input  logic [TUSER_L-1:0] axi_s_tuser_i,
   input  logic [TKEEP_L-1:0] axi_s_tkeep_i,
   input  logic               axi_s_tlast_i,
   input  logic               axi_s_tvalid_i,
   output logic               axi_s_tready_o,
   output logic [TDATA_L-1:0] axi_m0_tdata_o,
   output logic [TUSER_L-1:0] axi_m0_tuser_o,
   output logic [TKEEP_L-1:0] axi_m0_tkeep_o,
   output logic               axi_m0_tlast_o,
   output logic               axi_m0_tvalid_o,
   input  logic               axi_m0_tready_i,
   output logic [TDATA_L-1:0] axi_m1_tdata_o,
   output logic [TUSER_L-1:0] axi_m1_tuser_o,
   output logic [TKEEP_L-1:0] axi_m1_tkeep_o,
   output logic               axi_m1_tlast_o,
   output logic               axi_m1_tvalid_o,
   input  logic               axi_m1_tready_i,
   output logic [TDATA_L-1:0] axi_m2_tdata_o,
   output logic [TUSER_L-1:0] axi_m2_tuser_o,
   output logic [TKEEP_L-1:0] axi_m2_tkeep_o,
   output logic               axi_m2_tlast_o,
   output logic               axi_m2_tvalid_o,
   input  logic               axi_m2_tready_i,
   output logic [15:0]        drop_cnt_o,
   output logic               busy_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_t;

   state_t             r_state;
   logic [1:0]         r_lock;
   logic [15:0]        r_drop_cnt;
   logic               r_out_vld;
   logic [1:0]         r_out_sel;
   logic [TDATA_L-1:0] r_out_data;
   logic [TUSER_L-1:0] r_out_user;
   logic [TKEEP_L-1:0] r_out_keep;
   logic               r_out_last;

   logic [1:0]         w_dest;
   logic               w_dest_en;
   logic               w_drop_dec;
   logic               w_sel_ready;
   logic               w_acc;
   logic               w_s_tready;
   logic               w_hs;
   logic               w_load;
   logic [1:0]         w_load_sel;

   assign w_dest     = axi_s_tuser_i[DEST_LSB +: 2];
   assign w_drop_dec = (w_dest == 2'd3) || !w_dest_en;
   assign w_acc      = !r_out_vld || w_sel_ready;
   assign w_hs       = axi_s_tvalid_i && w_s_tready;
   // Only IDLE heads with a live destination and FWD body beats enter the register.
   assign w_load     = w_hs && (((r_state == ST_IDLE) && !w_drop_dec) || (r_state == ST_FWD));
   assign w_load_sel = (r_state == ST_FWD) ? r_lock : w_dest;

   // Enable lookup for the head destination; destination 3 has no port.
   always_comb begin
      w_dest_en = 1'b0;
      case (w_dest)
         2'd0:    w_dest_en = port_enable_i[0];
         2'd1:    w_dest_en = port_enable_i[1];
         2'd2:    w_dest_en = port_enable_i[2];
         default: w_dest_en = 1'b0;
      endcase
   end

   // Ready of the master currently addressed by the output register.
   always_comb begin
      w_sel_ready = 1'b0;
      case (r_out_sel)
         2'd0:    w_sel_ready = axi_m0_tready_i;
         2'd1:    w_sel_ready = axi_m1_tready_i;
         2'd2:    w_sel_ready = axi_m2_tready_i;
         default: w_sel_ready = 1'b0;
      endcase
   end

   // Slave ready: dropped beats never wait on the output register.
   always_comb begin
      w_s_tready = w_acc;
      case (r_state)
         ST_IDLE: w_s_tready = w_drop_dec ? 1'b1 : w_acc;
         ST_FWD:  w_s_tready = w_acc;
         ST_DROP: w_s_tready = 1'b1;
         default: w_s_tready = w_acc;
      endcase
   end

   // Packet FSM: tracks FWD/DROP across packet bodies and counts dropped packets.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_lock     <= 2'd0;
         r_drop_cnt <= 16'd0;
      end else if (w_hs) begin
         case (r_state)
            ST_IDLE: begin
               if (w_drop_dec) begin
                  if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
                  if (!axi_s_tlast_i) r_state <= ST_DROP;
               end else if (!axi_s_tlast_i) begin
                  r_state <= ST_FWD;
                  r_lock  <= w_dest;
               end
            end
            ST_FWD:  if (axi_s_tlast_i) r_state <= ST_IDLE;
            ST_DROP: if (axi_s_tlast_i) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Output register control: load wins over drain so a same-cycle swap stays valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_vld <= 1'b0;
         r_out_sel <= 2'd0;
      end else if (w_load) begin
         r_out_vld <= 1'b1;
         r_out_sel <= w_load_sel;
      end else if (r_out_vld && w_sel_ready) begin
         r_out_vld <= 1'b0;
      end
   end

   // Output register payload; qualified by r_out_vld so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_out_data <= axi_s_tdata_i;
         r_out_user <= axi_s_tuser_i;
         r_out_keep <= axi_s_tkeep_i;
         r_out_last <= axi_s_tlast_i;
      end
   end

   assign axi_s_tready_o  = w_s_tready;

   assign axi_m0_tdata_o  = r_out_data;
   assign axi_m0_tuser_o  = r_out_user;
   assign axi_m0_tkeep_o  = r_out_keep;
   assign axi_m0_tlast_o  = r_out_last;
   assign axi_m0_tvalid_o = r_out_vld && (r_out_sel == 2'd0);

   assign axi_m1_tdata_o  = r_out_data;
   assign axi_m1_tuser_o  = r_out_user;
   assign axi_m1_tkeep_o  = r_out_keep;
   assign axi_m1_tlast_o  = r_out_last;
   assign axi_m1_tvalid_o = r_out_vld && (r_out_sel == 2'd1);

   assign axi_m2_tdata_o  = r_out_data;
   assign axi_m2_tuser_o  = r_out_user;
   assign axi_m2_tkeep_o  = r_out_keep;
   assign axi_m2_tlast_o  = r_out_last;
   assign axi_m2_tvalid_o = r_out_vld && (r_out_sel == 2'd2);

   assign drop_cnt_o = r_drop_cnt;
   assign busy_o     = (r_state != ST_IDLE) || r_out_vld;

endmodule

// File: tb/tb_axis_demux_13.sv
// tb_axis_demux_13 -- directed bench for the 1-to-3 AXI4-Stream router.
module tb_axis_demux_13;

   localparam int TDATA_L  = 512;
   localparam int TUSER_L  = 81;
   localparam int TKEEP_L  = 16;
   localparam int DEST_LSB = 0;

   logic               clk;
   logic               rst_n;
   logic [2:0]         port_enable;
   logic [TDATA_L-1:0] s_tdata;
   logic [TUSER_L-1:0] s_tuser;
   logic [TKEEP_L-1:0] s_tkeep;
   logic               s_tlast, s_tvalid, s_tready;
   logic [TDATA_L-1:0] m0_tdata, m1_tdata, m2_tdata;
   logic [TUSER_L-1:0] m0_tuser, m1_tuser, m2_tuser;
   logic [TKEEP_L-1:0] m0_tkeep, m1_tkeep, m2_tkeep;
   logic               m0_tlast, m1_tlast, m2_tlast;
   logic               m0_tvalid, m1_tvalid, m2_tvalid;
   logic               m0_tready, m1_tready, m2_tready;
   logic [15:0]        drop_cnt;
   logic               busy;

   int n_cmp  = 0;
   int n_fail = 0;

   axis_demux_13 #(
      .TDATA_L(TDATA_L), .TUSER_L(TUSER_L), .TKEEP_L(TKEEP_L), .DEST_LSB(DEST_LSB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .port_enable_i(port_enable),
      .axi_s_tdata_i(s_tdata), .axi_s_tuser_i(s_tuser), .axi_s_tkeep_i(s_tkeep),
      .axi_s_tlast_i(s_tlast), .axi_s_tvalid_i(s_tvalid), .axi_s_tready_o(s_tready),
      .axi_m0_tdata_o(m0_tdata), .axi_m0_tuser_o(m0_tuser), .axi_m0_tkeep_o(m0_tkeep),
      .axi_m0_tlast_o(m0_tlast), .axi_m0_tvalid_o(m0_tvalid), .axi_m0_tready_i(m0_tready),
      .axi_m1_tdata_o(m1_tdata), .axi_m1_tuser_o(m1_tuser), .axi_m1_tkeep_o(m1_tkeep),
      .axi_m1_tlast_o(m1_tlast), .axi_m1_tvalid_o(m1_tvalid), .axi_m1_tready_i(m1_tready),
      .axi_m2_tdata_o(m2_tdata), .axi_m2_tuser_o(m2_tuser), .axi_m2_tkeep_o(m2_tkeep),
      .axi_m2_tlast_o(m2_tlast), .axi_m2_tvalid_o(m2_tvalid), .axi_m2_tready_i(m2_tready),
      .drop_cnt_o(drop_cnt), .busy_o(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [TDATA_L-1:0] mk_data(input logic [7:0] tag);
      return {(TDATA_L/32){24'h5EED00 | 24'(tag), tag}};
   endfunction

   function automatic logic [TUSER_L-1:0] mk_user(input logic [7:0] tag, input logic [1:0] dest);
      logic [TUSER_L-1:0] u;
      u = '0;
      u[TUSER_L-1 -: 8] = tag;
      u[40 +: 8]        = ~tag;
      u[DEST_LSB +: 2]  = dest;
      return u;
   endfunction

   function automatic logic [TKEEP_L-1:0] mk_keep(input logic [7:0] tag);
      return {tag, ~tag};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] tag, input logic [1:0] dest, input logic last,
                        input logic vld);
      s_tdata  = mk_data(tag);
      s_tuser  = mk_user(tag, dest);
      s_tkeep  = mk_keep(tag);
      s_tlast  = last;
      s_tvalid = vld;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      port_enable = 3'b111;
      m0_tready = 1'b1; m1_tready = 1'b1; m2_tready = 1'b1;
      drive(8'h01, 2'd1, 1'b1, 1'b1);
      step(); step(); step();
      s_tvalid = 1'b0;
      rst_n = 1'b1;
      #1;
      n_cmp++; if ({m0_tvalid, m1_tvalid, m2_tvalid} !== 3'b000) begin n_fail++; $display("FAIL reset_tvalid got=%b exp=000", {m0_tvalid, m1_tvalid, m2_tvalid}); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt got=%h exp=0000", drop_cnt); end
      step();
      n_cmp++; if (m1_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_no_leak got=%b exp=0", m1_tvalid); end
   endtask

   task automatic test_single_beat();
      drive(8'h11, 2'd1, 1'b1, 1'b1);
      #1;
      n_cmp++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL single_tready got=%b exp=1", s_tready); end
      step();
      s_tvalid = 1'b0;
      n_cmp++; if (m1_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_m1_vld got=%b exp=1", m1_tvalid); end
      n_cmp++; if (m1_tdata !== mk_data(8'h11)) begin n_fail++; $display("FAIL single_data got=%h exp=%h", m1_tdata, mk_data(8'h11)); end
      n_cmp++; if (m1_tuser !== mk_user(8'h11, 2'd1)) begin n_fail++; $display("FAIL single_user got=%h exp=%h", m1_tuser, mk_user(8'h11, 2'd1)); end
      n_cmp++; if (m1_tkeep !== mk_keep(8'h11)) begin n_fail++; $display("FAIL single_keep got=%h exp=%h", m1_tkeep, mk_keep(8'h11)); end
      n_cmp++; if (m1_tlast !== 1'b1) begin n_fail++; $display("FAIL single_last got=%b exp=1", m1_tlast); end
      n_cmp++; if ({m0_tvalid, m2_tvalid} !== 2'b00) begin n_fail++; $display("FAIL single_others got=%b exp=00", {m0_tvalid, m2_tvalid}); end
      n_cmp++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL single_drop_cnt got=%h exp=0000", drop_cnt); end
      step();
      n_cmp++; if ({m1_tvalid, busy} !== 2'b00) begin n_fail++; $display("FAIL single_drain got=%b exp=00", {m1_tvalid, busy}); end
   endtask

   task automatic test_multi_beat();
      for (int i = 0; i < 4; i++) begin
         drive(8'(8'h20 + i), (i == 0) ? 2'd2 : 2'd0, i == 3, 1'b1);
         #1;
         n_cmp++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL multi_tready beat=%0d got=%b exp=1", i, s_tready); end
         step();
         n_cmp++; if (m2_tvalid !== 1'b1) begin n_fail++; $display("FAIL multi_m2_vld beat=%0d got=%b exp=1", i, m2_tvalid); end
         n_cmp++; if (m2_tdata !== mk_data(8'(8'h20 + i))) begin n_fail++; $display("FAIL multi_data beat=%0d got=%h", i, m2_tdata[31:0]); end
         n_cmp++; if (m2_tlast !== (i == 3)) begin n_fail++; $display("FAIL multi_last beat=%0d got=%b exp=%b", i, m2_tlast, i == 3); end
         n_cmp++; if ({m0_tvalid, m1_tvalid} !== 2'b00) begin n_fail++; $display("FAIL multi_others beat=%0d got=%b exp=00", i, {m0_tvalid, m1_tvalid}); end
      end
      s_tvalid = 1'b0;
      step();
      n_cmp++; if ({m2_tvalid, busy} !== 2'b00) begin n_fail++; $display("FAIL multi_idle got=%b exp=00", {m2_tvalid, busy}); end
   endtask

   task automatic test_stall();
      int idx = 0;
      int rx  = 0;
      logic [TDATA_L-1:0] held;
      held = '0;
      for (int c = 0; c < 20 && rx < 4; c++) begin
         m0_tready = !(c >= 2 && c <= 4);
         if (idx < 4) drive(8'(8'hA0 + idx), (idx == 0) ? 2'd0 : 2'd1, idx == 3, 1'b1);
         else s_tvalid = 1'b0;
         #1;
         if (c >= 2 && c <= 4) begin
            n_cmp++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL stall_tready cyc=%0d got=%b exp=0", c, s_tready); end
         end
         if (c >= 3 && c <= 4) begin
            n_cmp++; if (m0_tdata !== held || m0_tvalid !== 1'b1) begin n_fail++; $display("FAIL stall_stable cyc=%0d got=%h exp=%h", c, m0_tdata[31:0], held[31:0]); end
         end
         held = m0_tdata;
         if (m0_tvalid && m0_tready) begin
            n_cmp++; if (m0_tdata[7:0] !== 8'(8'hA0 + rx) || m0_tlast !== (rx == 3)) begin n_fail++; $display("FAIL stall_order rx=%0d got=%h/%b exp=%h/%b", rx, m0_tdata[7:0], m0_tlast, 8'(8'hA0 + rx), rx == 3); end
            rx++;
         end
         n_cmp++; if ({m1_tvalid, m2_tvalid} !== 2'b00) begin n_fail++; $display("FAIL stall_others cyc=%0d got=%b exp=00", c, {m1_tvalid, m2_tvalid}); end
         if (s_tvalid && s_tready) idx++;
         step();
      end
      s_tvalid = 1'b0;
      m0_tready = 1'b1;
      n_cmp++; if (rx !== 4 || idx !== 4) begin n_fail++; $display("FAIL stall_count got=rx%0d/tx%0d exp=4/4", rx, idx); end
      n_cmp++; if ({m0_tvalid, busy} !== 2'b00) begin n_fail++; $display("FAIL stall_idle got=%b exp=00", {m0_tvalid, busy}); end
   endtask

   task automatic test_ordering();
      m0_tready = 1'b0;
      drive(8'h40, 2'd0, 1'b1, 1'b1);
      #1;
      n_cmp++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL order_a_tready got=%b exp=1", s_tready); end
      step();
      for (int c = 0; c < 2; c++) begin
         drive(8'h41, 2'd1, 1'b1, 1'b1);
         #1;
         n_cmp++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL order_b_blocked cyc=%0d got=%b exp=0", c, s_tready); end
         n_cmp++; if ({m0_tvalid, m1_tvalid} !== 2'b10) begin n_fail++; $display("FAIL order_a_held cyc=%0d got=%b exp=10", c, {m0_tvalid, m1_tvalid}); end
         step();
      end
      m0_tready = 1'b1;
      #1;
      n_cmp++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL order_b_accept got=%b exp=1", s_tready); end
      step();
      s_tvalid = 1'b0;
      n_cmp++; if ({m0_tvalid, m1_tvalid} !== 2'b01) begin n_fail++; $display("FAIL order_b_out got=%b exp=01", {m0_tvalid, m1_tvalid}); end
      n_cmp++; if (m1_tdata !== mk_data(8'h41)) begin n_fail++; $display("FAIL order_b_data got=%h", m1_tdata[31:0]); end
      step();
   endtask

   task automatic test_drop();
      for (int i = 0; i < 3; i++) begin
         drive(8'(8'h30 + i), (i == 0) ? 2'd3 : 2'd0, i == 2, 1'b1);
         #1;
         n_cmp++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL drop_tready beat=%0d got=%b exp=1", i, s_tready); end
         step();
         n_cmp++; if ({m0_tvalid, m1_tvalid, m2_tvalid} !== 3'b000) begin n_fail++; $display("FAIL drop_no_out beat=%0d got=%b exp=000", i, {m0_tvalid, m1_tvalid, m2_tvalid}); end
         if (i == 0) begin
            n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy got=%b exp=1", busy); end
         end
      end
      s_tvalid = 1'b0;
      n_cmp++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_cnt1 got=%h exp=0001", drop_cnt); end
      port_enable = 3'b110;
      drive(8'h38, 2'd0, 1'b1, 1'b1);
      step();
      s_tvalid = 1'b0;
      n_cmp++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL drop_cnt2 got=%h exp=0002", drop_cnt); end
      n_cmp++; if (m0_tvalid !== 1'b0) begin n_fail++; $display("FAIL drop_disabled_m0 got=%b exp=0", m0_tvalid); end
      port_enable = 3'b111;
      drive(8'h39, 2'd3, 1'b1, 1'b1);
      repeat (65532) @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      n_cmp++; if (drop_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL drop_cnt_fffe got=%h exp=fffe", drop_cnt); end
      s_tvalid = 1'b1;
      step(); step(); step();
      s_tvalid = 1'b0;
      n_cmp++; if (drop_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL drop_cnt_sat got=%h exp=ffff", drop_cnt); end
   endtask

   task automatic test_reset_midpacket();
      drive(8'h60, 2'd1, 1'b0, 1'b1);
      step();
      n_cmp++; if (m1_tvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_vld got=%b exp=1", m1_tvalid); end
      drive(8'h61, 2'd0, 1'b0, 1'b1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      s_tvalid = 1'b0;
      #1;
      n_cmp++; if ({m0_tvalid, m1_tvalid, m2_tvalid} !== 3'b000) begin n_fail++; $display("FAIL rstmid_tvalid got=%b exp=000", {m0_tvalid, m1_tvalid, m2_tvalid}); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      n_cmp++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_drop_cnt got=%h exp=0000", drop_cnt); end
      drive(8'h70, 2'd2, 1'b1, 1'b1);
      step();
      s_tvalid = 1'b0;
      n_cmp++; if ({m1_tvalid, m2_tvalid} !== 2'b01) begin n_fail++; $display("FAIL rstmid_route got=%b exp=01", {m1_tvalid, m2_tvalid}); end
      n_cmp++; if (m2_tdata !== mk_data(8'h70) || m2_tlast !== 1'b1) begin n_fail++; $display("FAIL rstmid_data got=%h/%b", m2_tdata[31:0], m2_tlast); end
      step();
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got=%b exp=0", busy); end
   endtask

   initial begin
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = '0;
      s_tuser  = '0;
      s_tkeep  = '0;
      test_reset();
      test_single_beat();
      test_multi_beat();
      test_stall();
      test_ordering();
      test_drop();
      test_reset_midpacket();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_demux_13.md
Name: axis_demux_13

Overview:
- 1-to-3 AXI4-Stream packet router. It is the fan-out counterpart of the 3:1 ingress arbiter switch.
- One slave stream is steered packet-by-packet to one of three master streams, using a 2-bit destination field in TUSER sampled on the head beat.
- Illegal or disabled destinations are consumed and discarded, and counted.
- A single output register stage gives registered master outputs.

Parameters:
TDATA_L, 512, data width
TUSER_L, 81, user width; forwarded unmodified
TKEEP_L, 16, keep width
DEST_LSB, 0, bit position of 2-bit destination field in TUSER (DEST_LSB+1 < TUSER_L)

Ports:
clk  in  1  clock; all ports synchronous
rst_n  in  1  synchronous active-low reset
port_enable_i  in  3  per-output enable; bit k=0 → packets for mk dropped
axi_s_tdata_i/tuser_i/tkeep_i/tlast_i/tvalid_i  in  TDATA_L/TUSER_L/TKEEP_L/1/1  slave stream
axi_s_tready_o  out  1  slave ready
axi_mK_tdata_o/tuser_o/tkeep_o/tlast_o/tvalid_o  out  TDATA_L/TUSER_L/TKEEP_L/1/1  master K stream, K=0,1,2
axi_mK_tready_i  in  1  master K ready
drop_cnt_o  out  16  dropped-packet count, saturating
busy_o  out  1  high when state≠IDLE or output register valid

Behaviour:
- Reset: rst_n synchronous, active-low; clock clk.
- Reset values: state=IDLE, out_vld=0, all mK_tvalid=0, drop_cnt=0, busy=0, lock=0.
- Any beat in flight or buffered at reset is discarded; the first beat after reset is a head beat.
- Output register: out_vld, out_sel[1:0], data/user/keep/last.
  - All mK_tdata/tuser/tkeep/tlast are driven from this register (broadcast).
  - mK_tvalid = out_vld && out_sel==K.
  - sel_ready = mK_tready_i for K=out_sel.
  - Register drains on out_vld && sel_ready.
- Accept: acc = !out_vld || sel_ready. Handshake hs = s_tvalid && s_tready.
- Latency: an accepted beat appears on its master 1 cycle later. Throughput is 1 beat/cycle when the target is ready.
- Decode (head beat only): dest = tuser[DEST_LSB+:2]. drop_dec = (dest==3) || !port_enable_i[dest].
- Destination bits on non-head beats are ignored. port_enable changes mid-packet have no effect.
- States:
  - IDLE:
    - s_tready = drop_dec ? 1 : acc.
    - On hs with drop_dec: drop_cnt += 1 (hold at 16'hFFFF); if !tlast → DROP.
    - On hs with !drop_dec: load register with out_sel=dest; if !tlast → FWD, lock=dest.
  - FWD:
    - s_tready = acc.
    - On hs: load register with out_sel=lock; if tlast → IDLE.
  - DROP:
    - s_tready = 1; nothing loaded.
    - On hs with tlast → IDLE.
- Single-beat packets (head with tlast) never leave IDLE.
- Ordering: strictly in order, no bypass.
  - A head for port j cannot load while the register holds an undrained beat for port i≠j (acc=0).
  - A head for a dropped destination is consumed immediately even while the register is stalled.
- Simultaneous drain and load in one cycle is legal: the register keeps out_vld=1 with the new beat.
- Protocol rules:
  - mK_tvalid never depends on mK_tready.
  - Register contents are stable while mK_tvalid=1 && !mK_tready.
  - No beat is lost or duplicated.
  - s_tready may depend combinationally on mK_tready and on s_tuser in IDLE.
- tkeep and tuser pass through unchanged. No straddle support. One clock domain.

Test Plan:
- Single beat, tuser[1:0]=1, tlast=1, all tready=1, enable=3'b111 → m1_tvalid=1 next cycle with identical data/keep/user/tlast=1; m0/m2 tvalid=0; drop_cnt=0.
- 4-beat packet, head dest=2, dest field of beats 2–4 set to 0 → all 4 beats on m2 on consecutive cycles, tlast only on beat 4, m0 never valid, state back to IDLE.
- Packet to m0 with m0_tready=0 for 3 cycles mid-packet → s_tready falls while register is full; m0 outputs are stable during the stall; the sequence 0xA0..0xA3 is received once each, in order.
- dest=3, 3-beat packet → s_tready=1 every cycle, no mK_tvalid, drop_cnt 0→1. Then enable=3'b110 with single beat dest=0 → dropped, drop_cnt=2. Preload count 16'hFFFE and drop 3 packets → count ends at 16'hFFFF.
- Packet A (1 beat, dest 0) then B head (dest 1) next cycle, m0_tready=0 for 2 cycles → B is not accepted until A drains. Then B appears on m1 exactly 1 cycle after acceptance.
- rst_n=0 for 1 cycle during beat 2 of a 4-beat FWD packet with out_vld=1 → all tvalid=0, busy=0 next cycle. Next input beat with dest=2, tlast=1 is routed to m2 as a fresh head.
